// File: rtl/mem_bus_pkg.sv
// Shared encodings for the SRAM bus responder: request kinds, FSM states and
// the two MMIO register addresses.
package mem_bus_pkg;

  localparam logic [1:0] KIND_FETCH = 2'b00;
  localparam logic [1:0] KIND_LOAD  = 2'b01;
  localparam logic [1:0] KIND_STORE = 2'b10;
  localparam logic [1:0] KIND_NOP   = 2'b11;

  localparam logic [15:0] MMIO_CNT_ADDR = 16'hBF00;
  localparam logic [15:0] MMIO_LED_ADDR = 16'hBF01;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  // Fetch and load drive the bus identically.
  function automatic logic is_read(input logic [1:0] kind);
    return (kind == KIND_FETCH) || (kind == KIND_LOAD);
  endfunction

endpackage

// File: rtl/mem_mmio_regs.sv
// Internal MMIO registers: free-running cycle counter (read-only) and LED
// register (read/write). Only instantiated when MEM_MMIO_EN is defined.
module mem_mmio_regs
  import mem_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic [15:0] addr_i,
  input  logic        we_i,
  input  logic [15:0] wdata_i,
  output logic        hit_o,
  output logic [15:0] rdata_o,
  output logic [15:0] led_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] led_q, led_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    led_d = led_q;
    // Stores to the counter address are silently dropped.
    if (we_i && (addr_i == MMIO_LED_ADDR)) begin
      led_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      led_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign hit_o   = (addr_i == MMIO_CNT_ADDR) || (addr_i == MMIO_LED_ADDR);
  assign rdata_o = (addr_i == MMIO_LED_ADDR) ? led_q :
                   (addr_i == MMIO_CNT_ADDR) ? cnt_q : 16'd0;
  assign led_o   = led_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Single-outstanding fetch/load/store responder driving an asynchronous SRAM
// with programmable wait states. Define MEM_MMIO_EN to serve 0xBF00/0xBF01 internally.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int WAIT_CYC = 1,
  parameter int SRAM_AW  = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_kind,
  input  logic [15:0]        req_addr,
  input  logic [15:0]        req_wdata,
  output logic               rsp_valid,
  output logic [1:0]         rsp_kind,
  output logic [15:0]        rsp_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_i,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [15:0]        led
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         kind_q, kind_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;

  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_kind_q, rsp_kind_d;
  logic [15:0]        rsp_rdata_q, rsp_rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        sram_dq_o_q, sram_dq_o_d;
  logic               sram_dq_oe_q, sram_dq_oe_d;
  logic               sram_ce_n_q, sram_ce_n_d;
  logic               sram_oe_n_q, sram_oe_n_d;
  logic               sram_we_n_q, sram_we_n_d;

  logic               hs;
  logic               mmio_hit;
  logic [15:0]        mmio_rdata;
  logic               in_bus;
  logic               store_d;

`ifdef MEM_MMIO_EN
  logic mmio_we;
  assign mmio_we = hs && (req_kind == KIND_STORE);

  mem_mmio_regs u_mmio (
    .clk     (clk),
    .rst_n_i (rst),
    .addr_i  (req_addr),
    .we_i    (mmio_we),
    .wdata_i (req_wdata),
    .hit_o   (mmio_hit),
    .rdata_o (mmio_rdata),
    .led_o   (led)
  );
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = 16'd0;
  assign led        = 16'd0;
`endif

  assign hs = req_ready_q && req_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kind_d      = hs ? req_kind  : kind_q;
    addr_d      = hs ? req_addr  : addr_q;
    wdata_d     = hs ? req_wdata : wdata_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d     = ((req_kind == KIND_NOP) || mmio_hit) ? ST_RESP : ST_SETUP;
          rsp_rdata_d = (mmio_hit && is_read(req_kind)) ? mmio_rdata : 16'd0;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = CNT_W'(WAIT_CYC);
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = is_read(kind_q) ? ST_RESP : ST_HOLD;
          if (is_read(kind_q)) begin
            rsp_rdata_d = sram_dq_i;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD:  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so every pin is a flop.
    store_d      = (kind_d == KIND_STORE);
    in_bus       = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    req_ready_d  = (state_d == ST_IDLE);
    rsp_valid_d  = (state_d == ST_RESP);
    rsp_kind_d   = (state_d == ST_RESP) ? kind_d : rsp_kind_q;
    sram_addr_d  = in_bus ? SRAM_AW'(addr_d) : sram_addr_q;
    sram_ce_n_d  = !in_bus;
    sram_oe_n_d  = !(is_read(kind_d) && ((state_d == ST_SETUP) || (state_d == ST_STROBE)));
    sram_we_n_d  = !(store_d && (state_d == ST_STROBE));
    sram_dq_oe_d = store_d && in_bus;
    sram_dq_o_d  = sram_dq_oe_d ? wdata_d : 16'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      kind_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_kind_q   <= '0;
      rsp_rdata_q  <= '0;
      sram_addr_q  <= '0;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
      sram_ce_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_kind_q   <= rsp_kind_d;
      rsp_rdata_q  <= rsp_rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_dq_o_q  <= sram_dq_o_d;
      sram_dq_oe_q <= sram_dq_oe_d;
      sram_ce_n_q  <= sram_ce_n_d;
      sram_oe_n_q  <= sram_oe_n_d;
      sram_we_n_q  <= sram_we_n_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_kind   = rsp_kind_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = sram_dq_o_q;
  assign sram_dq_oe = sram_dq_oe_q;
  assign sram_ce_n  = sram_ce_n_q;
  assign sram_oe_n  = sram_oe_n_q;
  assign sram_we_n  = sram_we_n_q;

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the multi-cycle MIPS16 core: accepts one fetch/load/store request at a time from the control/datapath side (instruction fetch feeding IR, load feeding LMD, store from the Mem state) and executes it on the external asynchronous SRAM bus with programmed wait states. It returns read data plus a one-cycle completion pulse, letting the control FSM stall on `rsp_valid` instead of assuming fixed memory timing.

## Interface
- `WAIT_CYC`, 1, extra strobe cycles beyond the minimum one (0..7)
- `SRAM_AW`, 18, SRAM address width; request address is zero-extended
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder idle; handshake when both high at a rising edge
- `req_kind`  in  2  00 fetch, 01 load, 10 store, 11 no-op
- `req_addr`  in  16  word address
- `req_wdata`  in  16  store data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_kind`  out  2  `req_kind` of the completing request
- `rsp_rdata`  out  16  read data, valid with `rsp_valid` (0 for store/no-op)
- `sram_addr`  out  `SRAM_AW`  SRAM address
- `sram_dq_i`  in  16  SRAM data in
- `sram_dq_o`  out  16  SRAM data out
- `sram_dq_oe`  out  1  drive `sram_dq_o` onto the bus
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low SRAM strobes
- `led`  out  16  MMIO LED register (0 when MMIO compiled out)

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RESP. All outputs registered.
- Reset (rst==0 at an edge): state IDLE, `req_ready`=0 while rst low, `rsp_valid`=0, `rsp_kind`=0, `rsp_rdata`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, all `_n` strobes=1, `led`=0, counters 0.
- IDLE: `req_ready`=1. On handshake latch kind/addr/wdata, `req_ready`→0.
  - fetch/load/store → SETUP; no-op → RESP.
- SETUP (1 cycle): `sram_addr` valid, `sram_ce_n`=0. Read: `sram_oe_n`=0. Store: `sram_dq_o`=wdata, `sram_dq_oe`=1, `we_n` still 1.
- STROBE (`WAIT_CYC`+1 cycles, down-counter): store holds `we_n`=0; read holds `oe_n`=0 and captures `sram_dq_i` into `rsp_rdata` at the final STROBE edge. Then read → RESP, store → HOLD.
- HOLD (store only, 1 cycle): `we_n`=1, address and data still driven (hold time).
- RESP (1 cycle): `rsp_valid`=1, strobes deasserted, `sram_dq_oe`=0 → IDLE.
- Fetch and load are bus-identical; only `rsp_kind` differs.
- `req_kind`/`req_addr`/`req_wdata` ignored outside the IDLE handshake.

## Timing
- Cycle 0 = handshake edge. Read: SETUP c1, STROBE c2..c(W+2), `rsp_valid` at c(W+3). Store: HOLD c(W+3), `rsp_valid` c(W+4). W=1: read 4, store 5. No-op: `rsp_valid` c1.
- `req_ready` low from c1 until IDLE re-entered the cycle after RESP; back-to-back read period W+4.
- `we_n` and `oe_n` never both 0; `sram_dq_oe` never 1 with `oe_n`=0.
- Reset mid-transaction: next edge forces reset values; no `rsp_valid` for the aborted request; partial SRAM write tolerated.
- `WAIT_CYC`=0: STROBE lasts exactly one cycle.

## Configuration
- `MEM_MMIO_EN` defined: addresses 0xBF00 (read-only free-running 16-bit cycle counter, wraps 0xFFFF→0, store ignored) and 0xBF01 (R/W LED register driving `led`) are served internally: IDLE → RESP directly, `rsp_valid` at c1, SRAM strobes stay inactive.
- Undefined: those addresses go to SRAM like any other; `led` tied 0; no counter.

## Structure
- `mem_bus_pkg`: req_kind encodings, state enum, MMIO address constants (0xBF00, 0xBF01).
- Sub-module `mem_mmio_regs` (counter + LED register, address decode hit flag), instantiated only under `MEM_MMIO_EN`.

## Test plan
- Reset then store 0x1234 to 0x0040 (W=1) -> `we_n` low exactly 2 cycles, data driven SETUP..HOLD, `rsp_valid` at c5, `rsp_kind`=10.
- Fetch 0x0040 with SRAM model returning 0x1234 -> `oe_n` low c1..c3, `rsp_rdata`=0x1234, `rsp_kind`=00 at c4.
- Back-to-back load/store with `req_valid` held high -> second handshake only after RESP, no overlapping strobes.
- rst low during STROBE of a store -> next edge `we_n`=1, `sram_dq_oe`=0, IDLE, no `rsp_valid`.
- No-op and W=0 read -> no-op `rsp_valid` c1 with rdata 0; read `rsp_valid` c3.
- `MEM_MMIO_EN`: store 0x00A5 to 0xBF01 -> `led`=0x00A5, SRAM untouched; two reads of 0xBF00 N cycles apart differ by N.
